// File: rtl/my_pe_seq.sv
// rtl/my_pe_seq.sv - sequenced FP32 dot-product PE with local weight RAM and serial FMA
//
// floating_point_MAC : fused a*b+c on IEEE-754 single (normal numbers, zero flush,
//                      truncating), LATENCY pipeline stages plus an output register.
//   aclk, aresetn                       clock, synchronous active-low reset
//   s_axis_{a,b,c}_tvalid/tdata         operand beat (all three valid together)
//   m_axis_result_tvalid/tdata          result beat, LATENCY+1 cycles after the input beat
//
// my_pe_seq : weight RAM (2**L_RAM_SIZE x 32) + FSM driving one MAC op at a time.
//   aclk, areset                        clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data, wr_err       weight write port (IDLE only), drop pulse
//   start/len, cmd_err                  command (len 0..2**L_RAM_SIZE), reject pulse
//   ain_valid/ain_ready/ain             activation stream
//   busy                                high outside IDLE
//   dout_valid/dout_ready/dout          held result

module floating_point_MAC #(
  parameter int LATENCY = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  input  logic        s_axis_c_tvalid,
  input  logic [31:0] s_axis_c_tdata,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata
);
  logic               w_sp, w_sc, w_sbig, w_ssmall, w_sr, w_pzero, w_czero;
  logic [23:0]        w_ma, w_mb, w_mc;
  logic [47:0]        w_mp;
  logic signed [11:0] w_ep, w_ec, w_ebig, w_er;
  logic [11:0]        w_diff;
  logic [49:0]        w_xp, w_xc, w_big, w_small, w_small_al, w_sum, w_norm;
  logic [5:0]         w_p;
  logic [31:0]        w_res;
  logic [LATENCY:0]   r_vld;
  logic [31:0]        r_dat [0:LATENCY];

  always_comb begin
    w_ma    = {1'b1, s_axis_a_tdata[22:0]};
    w_mb    = {1'b1, s_axis_b_tdata[22:0]};
    w_mc    = {1'b1, s_axis_c_tdata[22:0]};
    w_pzero = (s_axis_a_tdata[30:23] == 8'd0) || (s_axis_b_tdata[30:23] == 8'd0);
    w_czero = (s_axis_c_tdata[30:23] == 8'd0);
    w_mp    = w_ma * w_mb;
    w_sp    = s_axis_a_tdata[31] ^ s_axis_b_tdata[31];
    w_sc    = s_axis_c_tdata[31];
    // Product and addend share one frame: value = x * 2**(e - 127 - 46).
    // A zero operand gets a tiny exponent so it never becomes the alignment reference.
    w_ep = w_pzero ? -12'sd512 : $signed({4'b0, s_axis_a_tdata[30:23]})
                                 + $signed({4'b0, s_axis_b_tdata[30:23]}) - 12'sd127;
    w_ec = w_czero ? -12'sd512 : $signed({4'b0, s_axis_c_tdata[30:23]});
    w_xp = w_pzero ? '0 : {2'b0, w_mp};
    w_xc = w_czero ? '0 : {3'b0, w_mc, 23'b0};
    if (w_ep >= w_ec) begin
      w_big = w_xp; w_sbig = w_sp; w_ebig = w_ep; w_small = w_xc; w_ssmall = w_sc;
      w_diff = w_ep - w_ec;
    end else begin
      w_big = w_xc; w_sbig = w_sc; w_ebig = w_ec; w_small = w_xp; w_ssmall = w_sp;
      w_diff = w_ec - w_ep;
    end
    w_small_al = (w_diff >= 12'd50) ? '0 : (w_small >> w_diff[5:0]);
    if (w_sbig == w_ssmall) begin
      w_sum = w_big + w_small_al; w_sr = w_sbig;
    end else if (w_big >= w_small_al) begin
      w_sum = w_big - w_small_al; w_sr = w_sbig;
    end else begin
      w_sum = w_small_al - w_big; w_sr = w_ssmall;
    end
    w_p = 6'd0;
    for (int i = 0; i < 50; i++) begin
      if (w_sum[i]) w_p = 6'(i);
    end
    w_norm = w_sum << (6'd49 - w_p);
    w_er   = w_ebig + $signed({6'b0, w_p}) - 12'sd46;
    if (w_sum == '0 || w_er <= 12'sd0) w_res = 32'h0000_0000;
    else if (w_er >= 12'sd255)        w_res = {w_sr, 8'hFF, 23'b0};
    else                              w_res = {w_sr, w_er[7:0], 23'(w_norm >> 26)};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) r_vld <= '0;
    else          r_vld <= {r_vld[LATENCY-1:0], s_axis_a_tvalid & s_axis_b_tvalid & s_axis_c_tvalid};
    r_dat[0] <= w_res;
    for (int k = 1; k <= LATENCY; k++) r_dat[k] <= r_dat[k-1];
  end

  assign m_axis_result_tvalid = r_vld[LATENCY];
  assign m_axis_result_tdata  = r_dat[LATENCY];
endmodule

module my_pe_seq #(
  parameter int L_RAM_SIZE = 4,
  parameter int DATA_W     = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  wr_en,
  input  logic [L_RAM_SIZE-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_err,
  input  logic                  start,
  input  logic [L_RAM_SIZE:0]   len,
  output logic                  cmd_err,
  input  logic                  ain_valid,
  output logic                  ain_ready,
  input  logic [DATA_W-1:0]     ain,
  output logic                  busy,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_W-1:0]     dout
);
  if (DATA_W != 32) begin : g_bad_width
    $error("my_pe_seq: DATA_W must be 32 for the FP MAC");
  end

  localparam int DEPTH = 2 ** L_RAM_SIZE;
  localparam logic [L_RAM_SIZE:0] MAX_LEN = {1'b1, {L_RAM_SIZE{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_A, S_ISSUE, S_WAIT_M, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_ram [0:DEPTH-1];
  logic [L_RAM_SIZE:0] r_idx, r_len, w_idx_inc;
  logic [DATA_W-1:0]   r_psum, r_bin, r_a;
  logic                r_wr_err, r_cmd_err, w_issue, w_res_vld;
  logic [31:0]         w_res_data;

  assign w_idx_inc = r_idx + 1'b1;

  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    ain_ready  = 1'b0;
    dout_valid = 1'b0;
    dout       = '0;
    w_issue    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && len == '0)          w_next = S_DONE;
        else if (start && len <= MAX_LEN) w_next = S_FETCH;
      end
      S_FETCH: w_next = S_WAIT_A;
      S_WAIT_A: begin
        ain_ready = 1'b1;
        if (ain_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        w_next  = S_WAIT_M;
      end
      S_WAIT_M: begin
        if (w_res_vld) w_next = (w_idx_inc == r_len) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        dout_valid = 1'b1;
        dout       = r_psum;
        if (dout_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Weight RAM has no reset; writes land only while the PE is idle.
  always_ff @(posedge aclk) begin
    if (wr_en && r_state == S_IDLE) r_ram[wr_addr] <= wr_data;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_psum    <= '0;
      r_bin     <= '0;
      r_a       <= '0;
      r_wr_err  <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wr_err  <= wr_en && (r_state != S_IDLE);
      r_cmd_err <= start && ((r_state != S_IDLE) || (len > MAX_LEN));
      case (r_state)
        S_IDLE: if (start && len <= MAX_LEN) begin
          r_idx  <= '0;
          r_len  <= len;
          r_psum <= '0;
        end
        S_FETCH:  r_bin <= r_ram[r_idx[L_RAM_SIZE-1:0]];
        S_WAIT_A: if (ain_valid) r_a <= ain;
        S_WAIT_M: if (w_res_vld) begin
          r_psum <= w_res_data;
          r_idx  <= w_idx_inc;
        end
        default: ;
      endcase
    end
  end

  assign wr_err  = r_wr_err;
  assign cmd_err = r_cmd_err;

  // Only one op is ever in flight, so c=psum never races an older result.
  floating_point_MAC #(.LATENCY(3)) u_mac (
    .aclk                 (aclk),
    .aresetn              (~areset),
    .s_axis_a_tvalid      (w_issue),
    .s_axis_a_tdata       (r_a),
    .s_axis_b_tvalid      (w_issue),
    .s_axis_b_tdata       (r_bin),
    .s_axis_c_tvalid      (w_issue),
    .s_axis_c_tdata       (r_psum),
    .m_axis_result_tvalid (w_res_vld),
    .m_axis_result_tdata  (w_res_data)
  );
endmodule

// File: tb/tb_my_pe_seq.sv
// tb/tb_my_pe_seq.sv - table-driven self-checking bench for my_pe_seq
module tb_my_pe_seq;
  localparam int MAC_M = 3;
  localparam logic [31:0] F1  = 32'h3F80_0000, F2  = 32'h4000_0000, F3  = 32'h4040_0000;
  localparam logic [31:0] F4  = 32'h4080_0000, F6  = 32'h40C0_0000, F8  = 32'h4100_0000;
  localparam logic [31:0] F12 = 32'h4140_0000, F16 = 32'h4180_0000, F17 = 32'h4188_0000;

  logic        aclk = 1'b0, areset = 1'b1;
  logic        wr_en = 1'b0, wr_err, start = 1'b0, cmd_err;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0, ain = '0, dout;
  logic [4:0]  len = '0;
  logic        ain_valid = 1'b0, ain_ready, busy, dout_valid, dout_ready = 1'b0;

  int n_checks = 0, n_fail = 0;

  my_pe_seq #(.L_RAM_SIZE(4), .DATA_W(32)) dut (
    .aclk(aclk), .areset(areset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .start(start), .len(len), .cmd_err(cmd_err),
    .ain_valid(ain_valid), .ain_ready(ain_ready), .ain(ain),
    .busy(busy), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          wset;
    logic [4:0]  len;
    logic [31:0] ain;
    int          stall;
    int          hold;
    logic [31:0] exp;
    int          exp_hs;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr_word(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge aclk);
    wr_en = 1'b0;
  endtask

  task automatic load_set(input int ws);
    for (int i = 0; i < 16; i++) begin
      if (ws == 0)      wr_word(4'(i), (i == 0) ? F1 : (i == 1) ? F2 : (i == 2) ? F3 : F4);
      else if (ws == 1) wr_word(4'(i), F1);
      else              wr_word(4'(i), (i == 15) ? F2 : F1);
    end
  endtask

  // Runs one command; called and returns on a falling edge.
  task automatic run_cmd(input string nm, input logic [4:0] l, input logic [31:0] a,
                         input int stall, input int hold,
                         output int lat, output logic [31:0] res, output int hs, output int vcyc);
    int cyc, wcnt;
    bit accepted, inj;
    lat = -1; res = '0; hs = 0; vcyc = 0; wcnt = 0; accepted = 0; inj = 0;
    start = 1'b1; len = l;
    @(negedge aclk);
    start = 1'b0; cyc = 1;
    while (cyc < 400 && !accepted) begin
      if (inj) begin
        check({nm, "_cmd_err_busy"}, 32'(cmd_err), 32'd1);
        check({nm, "_wr_err_busy"}, 32'(wr_err), 32'd1);
        inj = 0;
      end
      ain_valid = 1'b0; ain = 32'hDEAD_BEEF; dout_ready = 1'b0;
      if (ain_ready) begin
        if (wcnt < stall) wcnt++;
        else begin ain_valid = 1'b1; ain = a; hs++; wcnt = 0; end
      end
      if (dout_valid) begin
        if (lat < 0) begin lat = cyc; res = dout; end
        else check({nm, "_dout_stable"}, dout, res);
        vcyc++;
        if (vcyc > hold) dout_ready = 1'b1;
        else if (vcyc == 1) begin
          start = 1'b1; len = 5'd1;
          wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h1234_5678;
          inj = 1;
        end
      end
      accepted = dout_valid && dout_ready;
      @(negedge aclk);
      cyc++; start = 1'b0; wr_en = 1'b0;
    end
    ain_valid = 1'b0; dout_ready = 1'b0;
    check({nm, "_accepted"}, 32'(accepted), 32'd1);
    check({nm, "_valid_after"}, 32'(dout_valid), 32'd0);
    check({nm, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t tbl[8];
    int lat, hs, vcyc;
    logic [31:0] res;

    tbl[0] = '{0, 5'd3,  F1, 0, 0, F6,  3};
    tbl[1] = '{0, 5'd3,  F2, 3, 0, F12, 3};
    tbl[2] = '{0, 5'd2,  F2, 1, 0, F6,  2};
    tbl[3] = '{0, 5'd0,  F1, 0, 0, 32'h0, 0};
    tbl[4] = '{0, 5'd1,  F1, 0, 5, F1,  1};
    tbl[5] = '{-1, 5'd1, F1, 0, 0, F1,  1};
    tbl[6] = '{1, 5'd16, F1, 0, 0, F16, 16};
    tbl[7] = '{2, 5'd16, F1, 0, 0, F17, 16};

    repeat (3) @(negedge aclk);
    check("reset_outputs", {26'b0, busy, ain_ready, dout_valid, cmd_err, wr_err, 1'b0}, 32'h0);
    check("reset_dout", dout, 32'h0);
    areset = 1'b0;
    @(negedge aclk);

    load_set(0);
    check("wr_err_idle", 32'(wr_err), 32'd0);

    for (int t = 0; t < 8; t++) begin
      string nm;
      nm = $sformatf("vec%0d", t);
      if (tbl[t].wset >= 0) load_set(tbl[t].wset);
      run_cmd(nm, tbl[t].len, tbl[t].ain, tbl[t].stall, tbl[t].hold, lat, res, hs, vcyc);
      check({nm, "_dout"}, res, tbl[t].exp);
      check({nm, "_latency"}, 32'(lat), 32'(1 + int'(tbl[t].len) * (4 + MAC_M + tbl[t].stall)));
      check({nm, "_handshakes"}, 32'(hs), 32'(tbl[t].exp_hs));
      check({nm, "_valid_cycles"}, 32'(vcyc), 32'(tbl[t].hold + 1));
    end

    // Illegal length: rejected with a pulse, PE stays idle.
    start = 1'b1; len = 5'd17;
    @(negedge aclk);
    start = 1'b0;
    check("badlen_cmd_err", 32'(cmd_err), 32'd1);
    check("badlen_busy", 32'(busy), 32'd0);
    @(negedge aclk);
    check("badlen_cmd_err_drop", 32'(cmd_err), 32'd0);
    check("badlen_busy_later", 32'(busy), 32'd0);

    // Reset while a MAC op is in flight.
    wr_word(4'd0, F2);
    start = 1'b1; len = 5'd1; ain_valid = 1'b1; ain = F4;
    @(negedge aclk);
    start = 1'b0;
    repeat (3) @(negedge aclk);
    ain_valid = 1'b0;
    check("pre_reset_busy", 32'(busy), 32'd1);
    areset = 1'b1;
    #1;
    check("async_reset_outs", {28'b0, busy, ain_ready, dout_valid, 1'b0}, 32'h0);
    check("async_reset_dout", dout, 32'h0);
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("post_reset_busy", 32'(busy), 32'd0);
    run_cmd("after_reset", 5'd1, F4, 0, 0, lat, res, hs, vcyc);
    check("after_reset_dout", res, F8);
    check("after_reset_latency", 32'(lat), 32'(1 + 4 + MAC_M));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
